// File: rtl/cordic_pipe.sv
// ----------------------------------------------------------------------------
// cordic_pipe
//
// Fully pipelined, parametrised CORDIC engine. Each transaction selects
// rotation mode (rotate (x,y) by angle z) or vectoring mode (magnitude and
// atan2 of (x,y), accumulated onto z). One transaction per cycle enters, and
// a single global advance signal stalls every stage together when the
// consumer is not ready.
//
// Pipeline: pre-rotation register, ITERATIONS micro-rotation registers,
// optional 1/K gain register, saturating output register.
// Latency = ITERATIONS + 2 + GAIN_COMP cycles.
//
// Parameters:
//   DATA_WIDTH  width of x/y/z ports (8..32)
//   ITERATIONS  number of micro-rotations (1..DATA_WIDTH-1)
//   GAIN_COMP   1 = scale x/y by 1/K, 0 = leave the CORDIC gain K on x/y
//   TAG_WIDTH   width of the sideband tag
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_mode               0 = rotation, 1 = vectoring
//   in_x, in_y            signed Q1.(W-1) operands
//   in_z                  signed binary angle, 2^W = full circle
//   in_tag                sideband tag, passed through
//   out_valid / out_ready output handshake
//   out_x, out_y          saturated signed results
//   out_z                 binary-angle result (wraps)
//   out_mode, out_tag     echo of the input fields
// ----------------------------------------------------------------------------
module cordic_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int ITERATIONS = 15,
    parameter int GAIN_COMP  = 1,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic signed [DATA_WIDTH-1:0] in_x,
    input  logic signed [DATA_WIDTH-1:0] in_y,
    input  logic signed [DATA_WIDTH-1:0] in_z,
    input  logic        [TAG_WIDTH-1:0]  in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_x,
    output logic signed [DATA_WIDTH-1:0] out_y,
    output logic signed [DATA_WIDTH-1:0] out_z,
    output logic                         out_mode,
    output logic        [TAG_WIDTH-1:0]  out_tag
);

    localparam int  W  = DATA_WIDTH;
    // Two guard bits: the CORDIC gain and the sqrt(2) growth of vectoring
    // stay below 4x full scale, so x/y never overflow before saturation.
    localparam int  IW = DATA_WIDTH + 2;
    localparam real PI = 3.14159265358979323846;

    // atan(2^-i) in binary-angle units, one W-bit entry per iteration.
    // Computed from a power series so no constants are hand-entered.
    function automatic logic [ITERATIONS*DATA_WIDTH-1:0] build_atan_table();
        logic [ITERATIONS*DATA_WIDTH-1:0] tbl;
        real scale, t, t2, term, sum;
        tbl   = '0;
        scale = 1.0;
        for (int k = 0; k < DATA_WIDTH; k++) scale = scale * 2.0;
        scale = scale / (2.0 * PI);
        t = 1.0;
        for (int i = 0; i < ITERATIONS; i++) begin
            if (i == 0) begin
                // The series converges too slowly at 1; atan(1) is exact.
                sum = PI / 4.0;
            end else begin
                t2   = t * t;
                term = t;
                sum  = 0.0;
                for (int k = 0; k < 40; k++) begin
                    if (k % 2 == 0) sum = sum + term / real'(2 * k + 1);
                    else            sum = sum - term / real'(2 * k + 1);
                    term = term * t2;
                end
            end
            tbl[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(longint'(sum * scale));
            t = t * 0.5;
        end
        return tbl;
    endfunction

    // round(2^(W-1) / K) where K = prod sqrt(1 + 2^-2i).
    function automatic logic [DATA_WIDTH-1:0] calc_gain();
        real k2, p, s, scale;
        k2 = 1.0;
        p  = 1.0;
        for (int i = 0; i < ITERATIONS; i++) begin
            k2 = k2 * (1.0 + p);
            p  = p * 0.25;
        end
        s = 1.5;
        for (int k = 0; k < 40; k++) s = 0.5 * (s + k2 / s);
        scale = 1.0;
        for (int k = 0; k < DATA_WIDTH - 1; k++) scale = scale * 2.0;
        return DATA_WIDTH'(longint'(scale / s));
    endfunction

    // Clamp a guard-extended value into the W-bit signed range.
    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [IW-1:0] v);
        logic [2:0] top;
        top = v[IW-1 -: 3];
        if (top == 3'b000 || top == 3'b111) saturate = v[W-1:0];
        else if (v[IW-1])                   saturate = {1'b1, {(W-1){1'b0}}};
        else                                saturate = {1'b0, {(W-1){1'b1}}};
    endfunction

    localparam logic [ITERATIONS*DATA_WIDTH-1:0] ATAN_TABLE = build_atan_table();
    localparam logic [DATA_WIDTH-1:0] QUARTER = {2'b01, {(DATA_WIDTH-2){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] HALF    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 0 input: sign-extend and pre-rotate so the remaining angle is
    // within +-90 degrees (rotation) or x is non-negative (vectoring).
    logic signed [IW-1:0] in_x_ext, in_y_ext, pre_x, pre_y;
    logic signed [W-1:0]  pre_z;

    assign in_x_ext = {{2{in_x[W-1]}}, in_x};
    assign in_y_ext = {{2{in_y[W-1]}}, in_y};

    always_comb begin
        pre_x = in_x_ext;
        pre_y = in_y_ext;
        pre_z = in_z;
        if (in_mode) begin
            if (in_x[W-1]) begin
                pre_x = -in_x_ext;
                pre_y = -in_y_ext;
                pre_z = in_z + HALF;
            end
        end else begin
            case (in_z[W-1 -: 2])
                2'b01: begin
                    pre_x = -in_y_ext;
                    pre_y = in_x_ext;
                    pre_z = in_z - QUARTER;
                end
                2'b10: begin
                    pre_x = in_y_ext;
                    pre_y = -in_x_ext;
                    pre_z = in_z + QUARTER;
                end
                default: ;
            endcase
        end
    end

    // Index 0 is the pre-rotation register; index i+1 holds the result of
    // micro-rotation i.
    logic signed [IW-1:0]  stage_x    [ITERATIONS+1];
    logic signed [IW-1:0]  stage_y    [ITERATIONS+1];
    logic signed [W-1:0]   stage_z    [ITERATIONS+1];
    logic                  stage_mode [ITERATIONS+1];
    logic [TAG_WIDTH-1:0]  stage_tag  [ITERATIONS+1];
    logic                  stage_vld  [ITERATIONS+1];

    // dir_pos[i] = 1 means d = +1 for micro-rotation i.
    logic [ITERATIONS-1:0] dir_pos;

    always_comb begin
        dir_pos = '0;
        for (int i = 0; i < ITERATIONS; i++) begin
            if (stage_mode[i]) dir_pos[i] = stage_y[i][IW-1];
            else               dir_pos[i] = ~stage_z[i][W-1];
        end
    end

    // Pre-rotation and micro-rotation registers, all gated by advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s <= ITERATIONS; s++) begin
                stage_x[s]    <= '0;
                stage_y[s]    <= '0;
                stage_z[s]    <= '0;
                stage_mode[s] <= 1'b0;
                stage_tag[s]  <= '0;
                stage_vld[s]  <= 1'b0;
            end
        end else if (advance) begin
            stage_x[0]    <= pre_x;
            stage_y[0]    <= pre_y;
            stage_z[0]    <= pre_z;
            stage_mode[0] <= in_mode;
            stage_tag[0]  <= in_tag;
            stage_vld[0]  <= in_valid;
            for (int i = 0; i < ITERATIONS; i++) begin
                stage_mode[i+1] <= stage_mode[i];
                stage_tag[i+1]  <= stage_tag[i];
                stage_vld[i+1]  <= stage_vld[i];
                if (dir_pos[i]) begin
                    stage_x[i+1] <= stage_x[i] - (stage_y[i] >>> i);
                    stage_y[i+1] <= stage_y[i] + (stage_x[i] >>> i);
                    stage_z[i+1] <= stage_z[i] - ATAN_TABLE[i*W +: W];
                end else begin
                    stage_x[i+1] <= stage_x[i] + (stage_y[i] >>> i);
                    stage_y[i+1] <= stage_y[i] - (stage_x[i] >>> i);
                    stage_z[i+1] <= stage_z[i] + ATAN_TABLE[i*W +: W];
                end
            end
        end
    end

    // Values feeding the output register, with or without the gain stage.
    logic signed [IW-1:0] fin_x, fin_y;
    logic signed [W-1:0]  fin_z;
    logic                 fin_mode, fin_vld;
    logic [TAG_WIDTH-1:0] fin_tag;

    generate
        if (GAIN_COMP != 0) begin : g_gain
            localparam logic [W-1:0] GAIN = calc_gain();
            localparam logic signed [IW+W:0] GAIN_EXT   = {{(IW+1){1'b0}}, GAIN};
            localparam logic signed [IW+W:0] ROUND_HALF = {{(IW+2){1'b0}}, 1'b1, {(W-2){1'b0}}};

            logic signed [IW+W:0] ext_x, ext_y, prod_x, prod_y;
            logic signed [IW-1:0] gain_x, gain_y;
            logic signed [W-1:0]  gain_z;
            logic                 gain_mode, gain_vld;
            logic [TAG_WIDTH-1:0] gain_tag;

            always_comb begin
                ext_x  = {{(W+1){stage_x[ITERATIONS][IW-1]}}, stage_x[ITERATIONS]};
                ext_y  = {{(W+1){stage_y[ITERATIONS][IW-1]}}, stage_y[ITERATIONS]};
                prod_x = ext_x * GAIN_EXT;
                prod_y = ext_y * GAIN_EXT;
            end

            // Multiply by 1/K in Q(W-1), round half-up, and drop back to IW bits.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    gain_x    <= '0;
                    gain_y    <= '0;
                    gain_z    <= '0;
                    gain_mode <= 1'b0;
                    gain_tag  <= '0;
                    gain_vld  <= 1'b0;
                end else if (advance) begin
                    gain_x    <= IW'((prod_x + ROUND_HALF) >>> (W-1));
                    gain_y    <= IW'((prod_y + ROUND_HALF) >>> (W-1));
                    gain_z    <= stage_z[ITERATIONS];
                    gain_mode <= stage_mode[ITERATIONS];
                    gain_tag  <= stage_tag[ITERATIONS];
                    gain_vld  <= stage_vld[ITERATIONS];
                end
            end

            assign fin_x    = gain_x;
            assign fin_y    = gain_y;
            assign fin_z    = gain_z;
            assign fin_mode = gain_mode;
            assign fin_tag  = gain_tag;
            assign fin_vld  = gain_vld;
        end else begin : g_no_gain
            assign fin_x    = stage_x[ITERATIONS];
            assign fin_y    = stage_y[ITERATIONS];
            assign fin_z    = stage_z[ITERATIONS];
            assign fin_mode = stage_mode[ITERATIONS];
            assign fin_tag  = stage_tag[ITERATIONS];
            assign fin_vld  = stage_vld[ITERATIONS];
        end
    endgenerate

    // Output register: saturate x/y back to W bits; holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_mode  <= 1'b0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= fin_vld;
            out_x     <= saturate(fin_x);
            out_y     <= saturate(fin_y);
            out_z     <= fin_z;
            out_mode  <= fin_mode;
            out_tag   <= fin_tag;
        end
    end

endmodule
